// File: rtl/fifo_arb_pkg.sv
// Shared definitions for the fifo_mem write arbiter: FSM encoding and width helper.
package fifo_arb_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_t;

    // Bits needed to index 'value' items; never less than 1 so N=1-style corners still give a legal vector.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request bit searching upward from last+1, with wrap.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          any,
    output logic [IW-1:0] winner
);

    assign any = |req;

    // Scan from the farthest offset down to the nearest so the nearest hit is written last and wins.
    always_comb begin
        logic [IW-1:0] w_idx;
        // NOTE: every variable gets a value before any condition, otherwise a latch is inferred.
        winner = '0;
        w_idx  = '0;
        for (int k = N; k >= 1; k--) begin
            w_idx = IW'((int'(last) + k) % N);
            if (req[w_idx]) begin
                winner = w_idx;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing the single write port of fifo_mem among N producers,
// with per-requester valid/ready handshakes and backpressure from fifo_full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic [N-1:0]          req_valid,
    input  logic [N*DW-1:0]       req_data,
    output logic [N-1:0]          req_ready,
    input  logic                  fifo_full,
    output logic                  fifo_wr,
    output logic [DW-1:0]         fifo_data,
    output logic [clog2(N)-1:0]   grant_id,
    output logic                  busy
);

    localparam int IW = clog2(N);
    localparam int BW = clog2(MAX_BURST + 1);

    arb_state_t    r_state;
    logic [IW-1:0] r_grant_id;
    logic [IW-1:0] r_last;
    logic [BW-1:0] r_beat;

    logic          w_any;
    logic [IW-1:0] w_winner;
    logic          w_gnt_valid;
    logic          w_slot_open;
    logic          w_xfer;
    logic          w_last_beat;

    rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req    (req_valid),
        .last   (r_last),
        .any    (w_any),
        .winner (w_winner)
    );

    // A slot is open only while granted, the FIFO has room and no soft reset is in flight.
    assign w_gnt_valid = req_valid[r_grant_id];
    assign w_slot_open = (r_state == ST_BURST) && !fifo_full && !clear;
    assign w_xfer      = w_slot_open && w_gnt_valid;
    assign w_last_beat = (r_beat == BW'(MAX_BURST - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant_id <= '0;
            r_last     <= IW'(N - 1);
            r_beat     <= '0;
        end else if (clear) begin
            r_state    <= ST_IDLE;
            r_grant_id <= '0;
            r_last     <= IW'(N - 1);
            r_beat     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_state    <= ST_BURST;
                        r_grant_id <= w_winner;
                        r_last     <= w_winner;
                        r_beat     <= '0;
                    end
                end
                ST_BURST: begin
                    // A full FIFO only stalls; dropping valid or reaching the burst limit ends the grant.
                    if (!w_gnt_valid) begin
                        r_state <= ST_IDLE;
                    end else if (w_xfer) begin
                        if (w_last_beat) begin
                            r_state <= ST_IDLE;
                            r_beat  <= '0;
                        end else begin
                            r_beat <= r_beat + BW'(1);
                        end
                    end
                end
            endcase
        end
    end

    assign fifo_wr   = w_xfer;
    assign fifo_data = req_data[r_grant_id*DW +: DW];
    assign req_ready = w_slot_open ? (N'(1) << r_grant_id) : '0;
    assign grant_id  = r_grant_id;
    assign busy      = (r_state == ST_BURST);

    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(fifo_wr && fifo_full));
    a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(req_ready));
    a_beat_bound : assert property (@(posedge clk) disable iff (!rst_n) r_beat <= BW'(MAX_BURST - 1));

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write arbiter that shares the single write port of the 16-entry, 8-bit `fifo_mem` among N producers. It holds a grant for a bounded burst and applies per-requester valid/ready handshakes. It also drives `wr`/`data_in` of the FIFO and backpressures producers from `fifo_full`. The block sits between the producer blocks and `fifo_mem`, on the same clock.

## Interface
- `N`, 4: number of requesters, 2..8.
- `DW`, 8: data width; must match the FIFO data width.
- `MAX_BURST`, 4: maximum transfers per grant, 1..16.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `clear`  in  1  synchronous soft reset; same effect as reset at the next edge.
- `req_valid`  in  N  bit i: requester i has a word.
- `req_data`  in  N*DW  requester i word at [i*DW +: DW].
- `req_ready`  out  N  bit i: word i is accepted this cycle.
- `fifo_full`  in  1  from `fifo_mem`.
- `fifo_wr`  out  1  to `fifo_mem` `wr`.
- `fifo_data`  out  DW  to `fifo_mem` `data_in`.
- `grant_id`  out  clog2(N)  current/last granted requester.
- `busy`  out  1  high while in BURST.

## Operation
- States:
  - IDLE: no grant.
  - BURST: grant held by `grant_id`.
- IDLE -> BURST when any `req_valid` is high. The winner is the first set bit searching from `(last+1) mod N` upward with wrap, where `last` is the previous winner. The winner is registered into `grant_id` and `last`, and the beat counter clears to 0.
- In BURST:
  - `req_ready[grant_id] = ~fifo_full`; all other `req_ready` bits are 0.
  - `fifo_wr = req_valid[grant_id] & ~fifo_full`.
  - `fifo_data = req_data[grant_id]`, as a combinational mux.
  - A transfer is `fifo_wr`=1; each transfer increments the beat counter.
- BURST -> IDLE at the edge ending a cycle where either:
  - `req_valid[grant_id]`=0 (release; no transfer that cycle), or
  - a transfer occurs with beat count == MAX_BURST-1 (burst limit).
- In IDLE, `fifo_wr`=0 and `req_ready`=0. There is one bubble cycle between grants.
- `fifo_full` stalls the burst without ending it. The grant is held while valid stays high, and the beat count is unchanged during the stall.
- `fifo_wr` is never asserted while `fifo_full`=1, so the FIFO's overflow flag is never set by this block.
- Beat counter width is clog2(MAX_BURST+1). It never exceeds MAX_BURST-1 at a transfer.
- Reset or `clear`:
  - state = IDLE, `grant_id` = 0, `last` = N-1, so requester 0 wins first; beat counter = 0.
  - Reset and `clear` mid-burst abort the burst. A word presented that cycle is not accepted under `clear`.
- Requester rules: once `req_valid[i]` is high it holds with stable data until `req_ready[i]`. Dropping valid while granted releases the grant.

## Timing
- Reset values: `fifo_wr`=0, `req_ready`=0, `grant_id`=0, `busy`=0.
- Arbitration latency: valid seen in IDLE at cycle t gives `busy`/`grant_id` at t+1. The first transfer is at t+1 if the FIFO is not full.
- The transfer path is combinational from `req_valid`/`fifo_full` to `fifo_wr`/`req_ready`. There is no combinational path from `req_valid` to `grant_id`.
- Sustained throughput is MAX_BURST words per MAX_BURST+1 cycles with all requesters busy.
- `clear` takes priority over all other state updates. `rst_n` takes priority over `clear`.

## Structure
- Shared package `fifo_arb_pkg` holds:
  - the state encoding (IDLE=0, BURST=1);
  - the clog2 function used for `grant_id` and beat-counter widths.
- Sub-module `rr_pick`: a combinational round-robin picker. Inputs are the request vector and `last`; outputs are `any` and `winner`. The arbiter instantiates it once. All registers live in `fifo_wr_arbiter`.

## Test plan
- Reset with all `req_valid`=1 (N=4, MAX_BURST=4) -> outputs 0 during reset. After release, grants run 0,1,2,3,0, each of 4 transfers, with a 1-cycle IDLE between grants. The FIFO fills after 16 words and `fifo_full`=1.
- Single requester 2 sends 3 words, then drops valid -> 3 transfers, then IDLE. The next request from 2 is granted again (no other requesters).
- FIFO pre-filled to 15 words, requester 1 valid with 4 words -> 1 transfer, then `fifo_full` stall with `req_ready`=0. A FIFO read frees a slot and the remaining transfers resume within the same grant, with beat count continuous and no overflow.
- Requesters 0 and 3 valid, `last`=0 -> 3 granted first, then 0. Wrap-around is correct.
- `clear` pulsed on the 2nd beat of a burst by requester 1 -> that beat is not accepted. Next cycle is IDLE with `grant_id`=0, and requester 0 wins first if it is valid.
- `rst_n` asserted mid-burst, asynchronously between edges -> `fifo_wr`, `req_ready`, and `busy` drop immediately, with no further FIFO writes.
